fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the pipelined MIPS CPU, sitting directly upstream of the instruction memory. It owns the program counter and drives the word address into the combinational instruction memory. It latches the returned word into the IF/ID pipeline register. It also handles stall, branch/jump redirect, syscall-exit halt and out-of-range fetch faults.

## Interface
Parameters:
- RESET_PC, 30'h00100000, word address loaded into PC on reset.
- MEM_LO, 30'h00100000, lowest legal instruction word address.
- MEM_HI, 30'h00100100, highest legal instruction word address (inclusive).

Ports:
- clk  in  1  Single clock; all state updates on its rising edge.
- rst  in  1  Synchronous, active-high reset.
- stall  in  1  Hazard unit request: hold PC and IF/ID contents.
- redirect  in  1  Taken branch/jump from a later stage.
- redirect_pc  in  30  Word-address target accompanying redirect.
- halt  in  1  Syscall exit (v0 == 10) detected downstream.
- inst_in  in  32  Word returned by instruction memory for pc_out, same cycle.
- pc_out  out  30  Current fetch word address to instruction memory.
- if_id_inst  out  32  Latched instruction.
- if_id_pc1  out  30  Latched fetch address + 1 (word), for link/branch math.
- if_id_valid  out  1  IF/ID holds a real instruction (0 = bubble).
- fault  out  1  Sticky: fetch attempted outside [MEM_LO, MEM_HI].
- running  out  1  High in RUN state.
- fetch_count  out  32  Instructions delivered to IF/ID since reset; saturating.

## Operation
- States: RUN and HALT. Reset enters RUN.
- Reset values: pc_out=RESET_PC, if_id_inst=0, if_id_pc1=0, if_id_valid=0, fault=0, running=1, fetch_count=0.
- Per-edge priority in RUN: rst > halt > fault check > redirect > stall > normal advance.
- halt=1: go to HALT and clear if_id_valid. PC and fetch_count are frozen.
- Fault check: pc_out < MEM_LO or pc_out > MEM_HI, with no redirect pending:
  - set fault, go to HALT, clear if_id_valid;
  - inst_in is not latched.
- redirect=1 (overrides stall):
  - pc <= redirect_pc, if_id_valid <= 0 (flush the wrong-path instruction);
  - if_id_inst and if_id_pc1 unchanged;
  - fetch_count not incremented.
- stall=1, redirect=0: pc, all if_id_* and fetch_count hold.
- Normal advance:
  - if_id_inst <= inst_in, if_id_pc1 <= pc+1, if_id_valid <= 1;
  - pc <= pc+1;
  - fetch_count <= fetch_count+1, saturating at 32'hFFFFFFFF.
- PC arithmetic is 30-bit modulo; 30'h3FFFFFFF+1 = 0. With the default MEM_HI the fault check fires first.
- HALT ignores stall, redirect and halt. Only rst leaves it. pc_out holds its last value.
- fault is sticky until rst.

## Timing
- Memory is combinational: inst_in corresponding to pc_out is consumed at the same edge.
- Fetch-to-IF/ID latency: 1 cycle. After reset release the first valid instruction appears at edge 1; if_id_valid=0 during cycle 0.
- Redirect costs one bubble: at the edge where redirect=1, if_id_valid goes 0. The target instruction is latched at the next edge.
- Stall asserted for N cycles leaves outputs unchanged for N edges.
- rst asserted mid-stream: all state returns to reset values at that edge, regardless of other inputs.
- halt is sampled on the edge; running falls the cycle after.

## Structure
- Shared package cpu_pkg holds:
  - RESET_PC, MEM_LO, MEM_HI constants (shared with the instruction memory);
  - state enum fetch_state_t {RUN, HALT};
  - SYS_EXIT = 10.
- One sub-module, if_id_reg: the IF/ID pipeline register with load, hold and flush controls. It lets decode-side hazard logic reuse it.
- PC, the state machine and the counter live in fetch_stage itself.

## Test plan
- Reset: rst=1 for 2 cycles -> pc_out=00100000, if_id_valid=0, fetch_count=0, running=1.
- Sequential fetch: release reset, memory returns 0x20020004, 0x2004000A -> at edges 1 and 2:
  - if_id_inst matches each word;
  - if_id_pc1 = 00100001 then 00100002;
  - fetch_count = 2.
- Stall during redirect: stall=1 for 3 cycles, redirect=1 with 00100010 in the middle cycle -> pc_out=00100010 next cycle, if_id_valid=0, fetch_count unchanged.
- Fault: redirect to 00100101 -> on the following edge:
  - fault=1, running=0, if_id_valid=0;
  - pc_out stays 00100101 thereafter.
- Halt: halt=1 while pc=00100005 -> HALT with pc frozen at 00100005. Later redirect/stall pulses have no effect; rst restores 00100000.
- Counter saturation: force fetch_count to FFFFFFFE and advance 3 times -> fetch_count reads FFFFFFFF.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants and fetch-stage types
package cpu_pkg;

   localparam logic [29:0] RESET_PC = 30'h00100000;
   localparam logic [29:0] MEM_LO   = 30'h00100000;
   localparam logic [29:0] MEM_HI   = 30'h00100100;

   localparam int unsigned SYS_EXIT = 10;

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with load, hold and flush
// Flush only drops the valid bit so the payload stays observable for debug.
module if_id_reg
   import cpu_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_load,
   input  logic        i_flush,
   input  logic [31:0] i_inst,
   input  logic [29:0] i_pc1,
   output logic [31:0] o_inst,
   output logic [29:0] o_pc1,
   output logic        o_valid
);

   logic [31:0] r_inst;
   logic [29:0] r_pc1;
   logic        r_valid;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_inst  <= 32'd0;
         r_pc1   <= 30'd0;
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_inst  <= i_inst;
         r_pc1   <= i_pc1;
         r_valid <= 1'b1;
      end else if (i_flush) begin
         r_valid <= 1'b0;
      end
   end

   assign o_inst  = r_inst;
   assign o_pc1   = r_pc1;
   assign o_valid = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: PC, RUN/HALT control, fetch counter
// Instruction memory is combinational, so inst_in belongs to the current PC.
module fetch_stage
   import cpu_pkg::*;
#(
   parameter logic [29:0] RESET_PC = cpu_pkg::RESET_PC,
   parameter logic [29:0] MEM_LO   = cpu_pkg::MEM_LO,
   parameter logic [29:0] MEM_HI   = cpu_pkg::MEM_HI
)(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_stall,
   input  logic        i_redirect,
   input  logic [29:0] i_redirect_pc,
   input  logic        i_halt,
   input  logic [31:0] i_inst_in,
   output logic [29:0] o_pc_out,
   output logic [31:0] o_if_id_inst,
   output logic [29:0] o_if_id_pc1,
   output logic        o_if_id_valid,
   output logic        o_fault,
   output logic        o_running,
   output logic [31:0] o_fetch_count
);

   fetch_state_t r_state;
   fetch_state_t w_state_next;
   logic [29:0]  r_pc;
   logic [29:0]  w_pc_next;
   logic [29:0]  w_pc_inc;
   logic [31:0]  r_fetch_count;
   logic         r_fault;
   logic         w_load;
   logic         w_flush;
   logic         w_set_fault;
   logic         w_out_of_range;

   assign w_pc_inc       = r_pc + 30'd1;
   assign w_out_of_range = (r_pc < MEM_LO) || (r_pc > MEM_HI);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= RUN;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Priority in RUN: halt, then range fault, then redirect, then stall.
   always_comb begin
      w_state_next = r_state;
      w_pc_next    = r_pc;
      w_load       = 1'b0;
      w_flush      = 1'b0;
      w_set_fault  = 1'b0;
      case (r_state)
         RUN: begin
            if (i_halt) begin
               w_state_next = HALT;
               w_flush      = 1'b1;
            end else if (!i_redirect && w_out_of_range) begin
               w_state_next = HALT;
               w_flush      = 1'b1;
               w_set_fault  = 1'b1;
            end else if (i_redirect) begin
               w_pc_next = i_redirect_pc;
               w_flush   = 1'b1;
            end else if (!i_stall) begin
               w_pc_next = w_pc_inc;
               w_load    = 1'b1;
            end
         end
         HALT: begin
            w_state_next = HALT;
         end
         default: begin
            w_state_next = HALT;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_pc          <= RESET_PC;
         r_fault       <= 1'b0;
         r_fetch_count <= 32'd0;
      end else begin
         r_pc <= w_pc_next;
         if (w_set_fault) begin
            r_fault <= 1'b1;
         end
         if (w_load && (r_fetch_count != 32'hFFFFFFFF)) begin
            r_fetch_count <= r_fetch_count + 32'd1;
         end
      end
   end

   if_id_reg u_if_id_reg (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_load  (w_load),
      .i_flush (w_flush),
      .i_inst  (i_inst_in),
      .i_pc1   (w_pc_inc),
      .o_inst  (o_if_id_inst),
      .o_pc1   (o_if_id_pc1),
      .o_valid (o_if_id_valid)
   );

   assign o_pc_out      = r_pc;
   assign o_fault       = r_fault;
   assign o_running     = (r_state == RUN);
   assign o_fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage with a behavioural model
module tb_fetch_stage;
   import cpu_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [29:0] redirect_pc = 30'd0;
   logic        halt = 1'b0;
   logic [31:0] inst_in;
   logic [29:0] pc_out;
   logic [31:0] if_id_inst;
   logic [29:0] if_id_pc1;
   logic        if_id_valid;
   logic        fault;
   logic        running;
   logic [31:0] fetch_count;

   int total = 0;
   int bad   = 0;

   logic [31:0] mem [0:511];

   typedef struct {
      logic [29:0] pc;
      logic [31:0] inst;
      logic [29:0] pc1;
      logic        valid;
      logic        fault;
      logic        running;
      logic [31:0] cnt;
   } exp_t;

   exp_t q[$];

   // Reference state
   logic [29:0] m_pc;
   logic [31:0] m_inst;
   logic [29:0] m_pc1;
   logic        m_valid;
   logic        m_fault;
   logic        m_running;
   logic [31:0] m_cnt;

   always #5 clk = ~clk;

   assign inst_in = mem[9'(pc_out - MEM_LO)];

   fetch_stage dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_stall       (stall),
      .i_redirect    (redirect),
      .i_redirect_pc (redirect_pc),
      .i_halt        (halt),
      .i_inst_in     (inst_in),
      .o_pc_out      (pc_out),
      .o_if_id_inst  (if_id_inst),
      .o_if_id_pc1   (if_id_pc1),
      .o_if_id_valid (if_id_valid),
      .o_fault       (fault),
      .o_running     (running),
      .o_fetch_count (fetch_count)
   );

   function automatic logic [31:0] mem_at(input logic [29:0] a);
      logic [29:0] off;
      off = a - MEM_LO;
      return mem[off[8:0]];
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_edge();
      if (rst) begin
         m_pc = RESET_PC; m_inst = 0; m_pc1 = 0; m_valid = 0;
         m_fault = 0; m_running = 1; m_cnt = 0;
      end else if (!m_running) begin
         // halted: nothing moves
      end else if (halt) begin
         m_running = 0; m_valid = 0;
      end else if (!redirect && (m_pc < MEM_LO || m_pc > MEM_HI)) begin
         m_fault = 1; m_running = 0; m_valid = 0;
      end else if (redirect) begin
         m_pc = redirect_pc; m_valid = 0;
      end else if (!stall) begin
         m_inst  = mem_at(m_pc);
         m_pc1   = m_pc + 30'd1;
         m_valid = 1;
         m_pc    = m_pc + 30'd1;
         if (m_cnt != 32'hFFFFFFFF) m_cnt = m_cnt + 1;
      end
   endtask

   task automatic step(input logic r, input logic h, input logic rd,
                       input logic [29:0] rpc, input logic s);
      exp_t e;
      rst = r; halt = h; redirect = rd; redirect_pc = rpc; stall = s;
      model_edge();
      e.pc = m_pc; e.inst = m_inst; e.pc1 = m_pc1; e.valid = m_valid;
      e.fault = m_fault; e.running = m_running; e.cnt = m_cnt;
      q.push_back(e);
      @(posedge clk);
      #2;
   endtask

   task automatic adv(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 30'd0, 0);
   endtask

   // Monitor: compares the DUT against the oldest pending expectation after each edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("pc_out", {2'b0, pc_out}, {2'b0, e.pc});
            chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, e.valid});
            chk("if_id_inst", if_id_inst, e.inst);
            chk("if_id_pc1", {2'b0, if_id_pc1}, {2'b0, e.pc1});
            chk("fault", {31'd0, fault}, {31'd0, e.fault});
            chk("running", {31'd0, running}, {31'd0, e.running});
            chk("fetch_count", fetch_count, e.cnt);
         end
      end
   end

   initial begin
      logic [29:0] tgt;
      logic        r, h, rd, s;
      for (int i = 0; i < 512; i++) mem[i] = $urandom;
      mem[0] = 32'h20020004;
      mem[1] = 32'h2004000A;
      m_pc = 0; m_inst = 0; m_pc1 = 0; m_valid = 0; m_fault = 0; m_running = 0; m_cnt = 0;
      @(posedge clk);
      #2;

      // reset then sequential fetch
      step(1, 0, 0, 30'd0, 0);
      step(1, 0, 0, 30'd0, 0);
      adv(2);

      // stall with redirect in the middle cycle
      step(0, 0, 0, 30'd0, 1);
      step(0, 0, 1, 30'h00100010, 1);
      step(0, 0, 0, 30'd0, 1);
      adv(2);

      // fault above MEM_HI via redirect
      step(0, 0, 1, 30'h00100101, 0);
      adv(3);
      step(0, 0, 1, 30'h00100020, 1);

      // walk off the top of memory from MEM_HI
      step(1, 0, 0, 30'd0, 0);
      step(0, 0, 1, MEM_HI, 0);
      adv(3);

      // fault below MEM_LO
      step(1, 0, 0, 30'd0, 0);
      step(0, 0, 1, 30'h000FFFFF, 0);
      adv(2);

      // halt at pc 00100005, then ignored pulses, then reset
      step(1, 0, 0, 30'd0, 0);
      adv(5);
      step(0, 1, 0, 30'd0, 0);
      step(0, 0, 1, 30'h00100030, 0);
      step(0, 0, 0, 30'd0, 1);
      step(0, 1, 1, 30'h00100040, 1);
      adv(2);
      step(1, 0, 0, 30'd0, 0);

      // counter saturation
      adv(1);
      rst = 0; halt = 0; redirect = 0; stall = 0;
      force dut.r_fetch_count = 32'hFFFFFFFE;
      #1;
      release dut.r_fetch_count;
      m_cnt = 32'hFFFFFFFE;
      adv(3);

      // randomized traffic
      step(1, 0, 0, 30'd0, 0);
      for (int n = 0; n < 3000; n++) begin
         r  = (($urandom % 97) == 0) || (!m_running && (($urandom % 4) == 0));
         h  = (($urandom % 150) == 0);
         rd = (($urandom % 8) == 0);
         s  = (($urandom % 4) == 0);
         case ($urandom % 8)
            0:       tgt = MEM_HI + 30'($urandom_range(1, 3));
            1:       tgt = MEM_LO - 30'd1;
            2:       tgt = MEM_HI - 30'($urandom_range(0, 3));
            default: tgt = MEM_LO + 30'($urandom_range(0, 32'h100));
         endcase
         step(r, h, rd, tgt, s);
      end

      step(1, 0, 0, 30'd0, 0);
      adv(2);
      @(posedge clk);
      #3;
      chk("scoreboard_drained", q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
